// File: rtl/puf_key_stabilizer_if.sv
// puf_key_stabilizer_if: request/key bus and puf_gen_256 drive/response signals of the key stabilizer.
interface puf_key_stabilizer_if;
   logic         start;
   logic [1:0]   challenge;
   logic         puf_enable;
   logic [1:0]   puf_control;
   logic [255:0] puf_response;
   logic         busy;
   logic         key_valid;
   logic [255:0] key;
   logic [8:0]   unstable_count;
   modport master (
      input  start, challenge, puf_response,
      output puf_enable, puf_control, busy, key_valid, key, unstable_count
   );
   modport slave (
      output start, challenge, puf_response,
      input  puf_enable, puf_control, busy, key_valid, key, unstable_count
   );
endinterface

// File: rtl/puf_key_stabilizer.sv
// puf_key_stabilizer: sequences puf_gen_256 through SAMPLES re-armed captures and majority-votes a stable key.
module puf_key_stabilizer #(
   parameter int SAMPLES       = 7,
   parameter int SETTLE_CYCLES = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   puf_key_stabilizer_if.master bus
);
   localparam int CW = $clog2(SAMPLES + 1);
   localparam int PW = $clog2(SETTLE_CYCLES + 2);
   typedef enum logic [2:0] {IDLE, OFF, SETTLE, FINISH, DONE} state_t;
   state_t          state, state_d;
   logic [PW-1:0]   phase;
   logic [CW-1:0]   idx;
   logic [CW-1:0]   cnt [256];
   logic [255:0]    key_d;
   logic [8:0]      unst_d;
   logic            accept, off_end, settle_end;
   assign accept     = (state == IDLE || state == DONE) && bus.start;
   assign off_end    = state == OFF && phase == PW'(1);
   assign settle_end = state == SETTLE && phase == PW'(SETTLE_CYCLES - 1);
   assign bus.puf_enable = state == SETTLE;
   assign bus.busy       = state == OFF || state == SETTLE || state == FINISH;
   assign bus.key_valid  = state == DONE;
   always_comb begin
      state_d = accept ? OFF :
                off_end ? SETTLE :
                settle_end ? (idx == CW'(SAMPLES - 1) ? FINISH : OFF) :
                state == FINISH ? DONE : state;
   end
   // A bit is unstable unless every sample agreed (all zeros or all ones).
   always_comb begin
      key_d  = '0;
      unst_d = '0;
      for (int i = 0; i < 256; i++) begin
         key_d[i] = cnt[i] > CW'(SAMPLES / 2);
         unst_d   = unst_d + 9'(cnt[i] != '0 && cnt[i] != CW'(SAMPLES));
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_d;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase              <= '0;
         idx                <= '0;
         bus.puf_control    <= '0;
         bus.key            <= '0;
         bus.unstable_count <= '0;
         for (int i = 0; i < 256; i++) cnt[i] <= '0;
      end else begin
         phase <= ((state == OFF && !off_end) || (state == SETTLE && !settle_end)) ? phase + PW'(1) : '0;
         if (accept) begin
            bus.puf_control    <= bus.challenge;
            bus.key            <= '0;
            bus.unstable_count <= '0;
            idx                <= '0;
            for (int i = 0; i < 256; i++) cnt[i] <= '0;
         end else if (settle_end) begin
            idx <= idx + CW'(1);
            for (int i = 0; i < 256; i++) cnt[i] <= cnt[i] + CW'(bus.puf_response[i]);
         end else if (state == FINISH) begin
            bus.key            <= key_d;
            bus.unstable_count <= unst_d;
         end
      end
   end
endmodule

// File: tb/tb_puf_key_stabilizer.sv
// tb_puf_key_stabilizer: directed checks of sequencing, voting, reset and restart of puf_key_stabilizer.
module tb_puf_key_stabilizer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   puf_key_stabilizer_if bus ();
   puf_key_stabilizer_if bus2 ();
   puf_key_stabilizer u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   puf_key_stabilizer #(.SAMPLES(1), .SETTLE_CYCLES(1)) u_small (.clk(clk), .rst_n(rst_n), .bus(bus2));
   localparam logic [255:0] KEY_A5 = {32{8'hA5}};
   localparam logic [255:0] KEY_DB = {8{32'hDEADBEEF}};
   int tests = 0;
   int fails = 0;
   logic [255:0] resp_tbl [7];
   int cap_n = 0;
   int cap_base = 0;
   logic [2:0] ci;
   int lat, pulses, bad_hi, bad_lo, bad_ctrl;
   logic e0_busy, e0_valid;
   logic [1:0] e0_ctrl;
   logic [255:0] e0_key;
   // Bench PUF: advances to the next table entry after each capture edge.
   always @(negedge bus.puf_enable) cap_n <= cap_n + 1;
   assign ci = 3'((cap_n - cap_base) % 7);
   assign bus.puf_response = resp_tbl[ci];
   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic run(input logic [1:0] ch, input int disturb_at, input int stop_at);
      int hi, lo;
      hi = 0; lo = 0; pulses = 0; bad_hi = 0; bad_lo = 0; bad_ctrl = 0; lat = -1;
      @(negedge clk);
      bus.challenge = ch;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      e0_busy = bus.busy; e0_valid = bus.key_valid; e0_key = bus.key; e0_ctrl = bus.puf_control;
      for (int n = 0; n <= 300 && n < stop_at; n++) begin
         if (n > 0) begin
            @(posedge clk);
            #1;
         end
         if (bus.puf_control !== ch) bad_ctrl++;
         if (bus.puf_enable) begin
            if (hi == 0 && lo != 2) bad_lo++;
            hi++;
            lo = 0;
         end else begin
            if (hi > 0) begin
               pulses++;
               if (hi != 16) bad_hi++;
            end
            hi = 0;
            lo++;
         end
         if (bus.key_valid) begin
            lat = n;
            break;
         end
         if (n == disturb_at) begin
            bus.start = 1'b1;
            bus.challenge = 2'b01;
         end
         if (n == disturb_at + 1) bus.start = 1'b0;
      end
      bus.start = 1'b0;
      bus.challenge = ch;
   endtask
   initial begin
      bus.start = 1'b1;
      bus.challenge = 2'($urandom);
      for (int i = 0; i < 7; i++) resp_tbl[i] = {8{$urandom}};
      bus2.start = 1'b1;
      bus2.challenge = 2'b11;
      bus2.puf_response = {8{$urandom}};
      repeat (3) @(posedge clk);
      #1;
      chk("rst_enable", bus.puf_enable, 0);
      chk("rst_control", bus.puf_control, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_valid", bus.key_valid, 0);
      chk("rst_key", bus.key, 0);
      chk("rst_unstable", bus.unstable_count, 0);
      chk("rst_small_busy", bus2.busy, 0);
      @(negedge clk);
      bus.start = 1'b0;
      bus2.start = 1'b0;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("idle_busy", bus.busy, 0);
      chk("idle_enable", bus.puf_enable, 0);
      chk("idle_valid", bus.key_valid, 0);
      // Constant response with start/challenge disturbance mid-run
      for (int i = 0; i < 7; i++) resp_tbl[i] = KEY_A5;
      cap_base = cap_n;
      run(2'b10, 50, 1000);
      chk("const_e0_ctrl", e0_ctrl, 2'b10);
      chk("const_e0_busy", e0_busy, 1);
      chk("const_pulses", pulses, 7);
      chk("const_pulse_len", bad_hi, 0);
      chk("const_off_len", bad_lo, 0);
      chk("const_ctrl_stable", bad_ctrl, 0);
      chk("const_latency", lat, 127);
      chk("const_key", bus.key, KEY_A5);
      chk("const_unstable", bus.unstable_count, 0);
      chk("const_done_busy", bus.busy, 0);
      chk("const_captures", cap_n - cap_base, 7);
      // Noisy bits, started from DONE
      for (int i = 0; i < 7; i++) begin
         resp_tbl[i] = 256'h80;
         resp_tbl[i][0] = i < 4;
         resp_tbl[i][255] = i < 3;
      end
      cap_base = cap_n;
      run(2'b10, -10, 1000);
      chk("restart_valid", e0_valid, 0);
      chk("restart_key", e0_key, 0);
      chk("restart_busy", e0_busy, 1);
      chk("noisy_latency", lat, 127);
      chk("noisy_key", bus.key, 256'h81);
      chk("noisy_unstable", bus.unstable_count, 2);
      // Reset in SETTLE of sample 3
      for (int i = 0; i < 7; i++) resp_tbl[i] = KEY_A5;
      cap_base = cap_n;
      run(2'b11, -10, 40);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_enable", bus.puf_enable, 0);
      chk("midrst_control", bus.puf_control, 0);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_valid", bus.key_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cap_base = cap_n;
      run(2'b11, -10, 1000);
      chk("midrst_latency", lat, 127);
      chk("midrst_key", bus.key, KEY_A5);
      chk("midrst_unstable", bus.unstable_count, 0);
      // SAMPLES=1, SETTLE_CYCLES=1 instance
      bus2.puf_response = KEY_DB;
      @(negedge clk);
      bus2.start = 1'b1;
      @(posedge clk);
      #1;
      bus2.start = 1'b0;
      lat = -1;
      for (int n = 0; n <= 20; n++) begin
         if (n > 0) begin
            @(posedge clk);
            #1;
         end
         if (n == 3) bus2.puf_response = ~KEY_DB;
         if (bus2.key_valid) begin
            lat = n;
            break;
         end
      end
      chk("small_latency", lat, 4);
      chk("small_key", bus2.key, KEY_DB);
      chk("small_unstable", bus2.unstable_count, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
